// File: rtl/game_pkg.sv
// Shared game-flow types and default constants.
// Imported by the game controller and its helpers.
package game_pkg;

  typedef enum logic [2:0] {
    START,
    ARM,
    PLAYING,
    PAUSED,
    GAMEOVER,
    DISARM
  } game_state_t;

  localparam int DEF_START_LIVES = 1;
  localparam int DEF_MAX_LIVES   = 9;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level-held button.
// Ports: clk_in, rst_in (sync high), level_in, rise_out.
module rise_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic level_in,
  output logic rise_out
);

  logic level_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) level_q <= 1'b0;
    else        level_q <= level_in;
  end

  assign rise_out = level_in & ~level_q;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: arm, play, pause, game over, re-arm.
// Ports: clk_in/rst_in, strobes pulse/died/got_powerup, buttons
// jump/pause_btn; registered status flags and counters out.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TIME_W       = 12,
  parameter int LIVES_W      = 4,
  parameter int START_LIVES  = DEF_START_LIVES,
  parameter int MAX_LIVES    = DEF_MAX_LIVES,
  parameter int INVULN_TICKS = 3,
  parameter int LEVEL_TICKS  = 30,
  parameter int LEVEL_W      = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               pulse,
  input  logic               died,
  input  logic               got_powerup,
  input  logic               jump,
  input  logic               pause_btn,
  output logic               playing,
  output logic               paused,
  output logic               game_over,
  output logic               reset_game,
  output logic               invulnerable,
  output logic [TIME_W-1:0]  time_alive,
  output logic [TIME_W-1:0]  best_time,
  output logic [LIVES_W-1:0] num_lives,
  output logic [LEVEL_W-1:0] level
);

  localparam int TICK_W =
    (LEVEL_TICKS < 3) ? 1 : $clog2(LEVEL_TICKS);
  localparam int INV_W =
    (INVULN_TICKS < 2) ? 1 : $clog2(INVULN_TICKS + 1);

  game_state_t        state;
  logic [TICK_W-1:0]  tick_cnt;
  logic [INV_W-1:0]   inv_cnt;
  logic               pause_rise;

  logic [TIME_W-1:0]  t_nxt;
  logic [TIME_W-1:0]  best_nxt;
  logic [LEVEL_W-1:0] lvl_nxt;
  logic [TICK_W-1:0]  tick_nxt;
  logic [INV_W-1:0]   inv_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic               hit;
  logic               fatal;

  rise_detect u_pause (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .level_in (pause_btn),
    .rise_out (pause_rise)
  );

  // Next counter values for one PLAYING cycle.
  always_comb begin
    t_nxt     = time_alive;
    lvl_nxt   = level;
    tick_nxt  = tick_cnt;
    inv_nxt   = inv_cnt;
    lives_nxt = num_lives;
    fatal     = 1'b0;
    hit       = died & ~invulnerable;
    if (pulse) begin
      if (time_alive != '1) t_nxt = time_alive + 1'b1;
      if (tick_cnt == TICK_W'(LEVEL_TICKS - 1)) begin
        tick_nxt = '0;
        if (level != '1) lvl_nxt = level + 1'b1;
      end else begin
        tick_nxt = tick_cnt + 1'b1;
      end
      if (inv_cnt != '0) inv_nxt = inv_cnt - 1'b1;
    end
    // A hit and a powerup in one cycle cancel out.
    unique case (1'b1)
      got_powerup & ~hit: begin
        if (num_lives < LIVES_W'(MAX_LIVES))
          lives_nxt = num_lives + 1'b1;
      end
      hit & ~got_powerup: begin
        if (num_lives <= LIVES_W'(1)) begin
          fatal = 1'b1;
        end else begin
          lives_nxt = num_lives - 1'b1;
          inv_nxt   = INV_W'(INVULN_TICKS);
        end
      end
      default: ;
    endcase
    best_nxt = (t_nxt > best_time) ? t_nxt : best_time;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= START;
      playing      <= 1'b0;
      paused       <= 1'b0;
      game_over    <= 1'b0;
      reset_game   <= 1'b1;
      invulnerable <= 1'b0;
      time_alive   <= '0;
      best_time    <= '0;
      num_lives    <= LIVES_W'(START_LIVES);
      level        <= '0;
      tick_cnt     <= '0;
      inv_cnt      <= '0;
    end else begin
      unique case (state)
        START: begin
          time_alive   <= '0;
          level        <= '0;
          tick_cnt     <= '0;
          inv_cnt      <= '0;
          invulnerable <= 1'b0;
          num_lives    <= LIVES_W'(START_LIVES);
          if (jump) begin
            state      <= ARM;
            reset_game <= 1'b0;
          end
        end
        ARM: begin
          if (!jump) begin
            state   <= PLAYING;
            playing <= 1'b1;
          end
        end
        PLAYING: begin
          time_alive <= t_nxt;
          level      <= lvl_nxt;
          tick_cnt   <= tick_nxt;
          num_lives  <= lives_nxt;
          if (fatal) begin
            state        <= GAMEOVER;
            playing      <= 1'b0;
            game_over    <= 1'b1;
            inv_cnt      <= '0;
            invulnerable <= 1'b0;
            best_time    <= best_nxt;
          end else begin
            inv_cnt      <= inv_nxt;
            invulnerable <= (inv_nxt != '0);
            if (pause_rise) begin
              state   <= PAUSED;
              playing <= 1'b0;
              paused  <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (pause_rise) begin
            state   <= PLAYING;
            playing <= 1'b1;
            paused  <= 1'b0;
          end
        end
        GAMEOVER: begin
          if (jump) state <= DISARM;
        end
        DISARM: begin
          if (!jump) begin
            state        <= START;
            game_over    <= 1'b0;
            reset_game   <= 1'b1;
            time_alive   <= '0;
            level        <= '0;
            tick_cnt     <= '0;
            inv_cnt      <= '0;
            invulnerable <= 1'b0;
            num_lives    <= LIVES_W'(START_LIVES);
          end
        end
        default: begin
          state        <= START;
          playing      <= 1'b0;
          paused       <= 1'b0;
          game_over    <= 1'b0;
          reset_game   <= 1'b1;
          invulnerable <= 1'b0;
          inv_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized and directed bench for game_ctrl.
// Compares the DUT against a cycle-level game-rules model.
module tb_game_ctrl;

  localparam int SL   = 2;
  localparam int ML   = 3;
  localparam int IT   = 2;
  localparam int LT   = 4;
  localparam int TMAX = 15;
  localparam int LMAX = 7;

  localparam int MS = 0;
  localparam int MA = 1;
  localparam int MP = 2;
  localparam int MZ = 3;
  localparam int MO = 4;
  localparam int MD = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse = 1'b0;
  logic died = 1'b0;
  logic pw = 1'b0;
  logic jump = 1'b0;
  logic pause_btn = 1'b0;

  logic       playing, paused, game_over, reset_game, invulnerable;
  logic [3:0] time_alive, best_time, num_lives;
  logic [2:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode, m_time, m_best, m_lives, m_level, m_ticks, m_inv;
  bit m_prev;

  always #5 clk = ~clk;

  game_ctrl #(
    .TIME_W       (4),
    .LIVES_W      (4),
    .START_LIVES  (SL),
    .MAX_LIVES    (ML),
    .INVULN_TICKS (IT),
    .LEVEL_TICKS  (LT),
    .LEVEL_W      (3)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .pulse        (pulse),
    .died         (died),
    .got_powerup  (pw),
    .jump         (jump),
    .pause_btn    (pause_btn),
    .playing      (playing),
    .paused       (paused),
    .game_over    (game_over),
    .reset_game   (reset_game),
    .invulnerable (invulnerable),
    .time_alive   (time_alive),
    .best_time    (best_time),
    .num_lives    (num_lives),
    .level        (level)
  );

  logic [23:0] dvec;
  assign dvec = {playing, paused, game_over, reset_game,
                 invulnerable, time_alive, best_time,
                 num_lives, level};

  function automatic logic [23:0] mvec();
    return {m_mode == MP, m_mode == MZ,
            (m_mode == MO) || (m_mode == MD),
            m_mode == MS, m_inv > 0,
            4'(m_time), 4'(m_best), 4'(m_lives), 3'(m_level)};
  endfunction

  task automatic clear_run();
    m_time = 0; m_level = 0; m_ticks = 0;
    m_lives = SL; m_inv = 0;
  endtask

  task automatic model_step();
    bit pe, hit, fatal;
    int inv0;
    pe = pause_btn && !m_prev;
    m_prev = pause_btn;
    if (rst) begin
      clear_run();
      m_mode = MS; m_best = 0; m_prev = 0;
      return;
    end
    case (m_mode)
      MS: begin
        clear_run();
        if (jump) m_mode = MA;
      end
      MA: if (!jump) m_mode = MP;
      MP: begin
        inv0 = m_inv;
        if (pulse) begin
          if (m_time < TMAX) m_time++;
          m_ticks++;
          if (m_ticks == LT) begin
            m_ticks = 0;
            if (m_level < LMAX) m_level++;
          end
          if (m_inv > 0) m_inv--;
        end
        hit = died && (inv0 == 0);
        fatal = 0;
        if (pw && !hit) begin
          if (m_lives < ML) m_lives++;
        end else if (hit && !pw) begin
          if (m_lives == 1) fatal = 1;
          else begin
            m_lives--;
            m_inv = IT;
          end
        end
        if (fatal) begin
          m_mode = MO;
          m_inv = 0;
          if (m_time > m_best) m_best = m_time;
        end else if (pe) begin
          m_mode = MZ;
        end
      end
      MZ: if (pe) m_mode = MP;
      MO: if (jump) m_mode = MD;
      MD: if (!jump) begin
        m_mode = MS;
        clear_run();
      end
      default: m_mode = MS;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic strobe_pulse(int n);
    pulse = 1'b1;
    repeat (n) step();
    pulse = 1'b0;
  endtask

  task automatic strobe_died();
    died = 1'b1; step(); died = 1'b0;
  endtask

  task automatic go_play();
    for (int k = 0; k < 3 && m_mode != MP; k++) begin
      jump = 1'b1; step(); step();
      jump = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_tests++;
    if (reset_game !== 1'b1 || num_lives !== 4'd2 ||
        playing !== 1'b0 || best_time !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state got %h want rg=1 lives=2", dvec);
    end
    n_tests++;
    if (dvec !== mvec()) begin
      n_fail++;
      $display("FAIL reset_vec got %h want %h", dvec, mvec());
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    jump = 1'b1; repeat (3) step();
    n_tests++;
    if (reset_game !== 1'b0 || playing !== 1'b0) begin
      n_fail++;
      $display("FAIL arm got rg=%b pl=%b want 0 0",
               reset_game, playing);
    end
    jump = 1'b0; step();
    n_tests++;
    if (playing !== 1'b1 || reset_game !== 1'b0 ||
        num_lives !== 4'd2) begin
      n_fail++;
      $display("FAIL start got pl=%b rg=%b lives=%0d want 1 0 2",
               playing, reset_game, num_lives);
    end
  endtask

  task automatic test_hit_window();
    strobe_died();
    n_tests++;
    if (num_lives !== 4'd1 || invulnerable !== 1'b1) begin
      n_fail++;
      $display("FAIL first_hit got lives=%0d inv=%b want 1 1",
               num_lives, invulnerable);
    end
    strobe_pulse(1);
    strobe_died();
    n_tests++;
    if (num_lives !== 4'd1 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL invuln_hit got lives=%0d go=%b want 1 0",
               num_lives, game_over);
    end
    strobe_pulse(1);
    n_tests++;
    if (invulnerable !== 1'b0) begin
      n_fail++;
      $display("FAIL invuln_expire got %b want 0", invulnerable);
    end
    strobe_died();
    n_tests++;
    if (game_over !== 1'b1 || playing !== 1'b0 ||
        best_time !== 4'd2 || time_alive !== 4'd2) begin
      n_fail++;
      $display("FAIL fatal_hit got go=%b best=%0d t=%0d want 1 2 2",
               game_over, best_time, time_alive);
    end
  endtask

  task automatic test_lives_cancel();
    go_play();
    pw = 1'b1; repeat (3) step(); pw = 1'b0;
    n_tests++;
    if (num_lives !== 4'd3) begin
      n_fail++;
      $display("FAIL powerup_sat got %0d want 3", num_lives);
    end
    died = 1'b1; pw = 1'b1; step();
    died = 1'b0; pw = 1'b0;
    n_tests++;
    if (num_lives !== 4'd3 || invulnerable !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel got lives=%0d inv=%b want 3 0",
               num_lives, invulnerable);
    end
    strobe_died();
    n_tests++;
    if (dvec !== mvec()) begin
      n_fail++;
      $display("FAIL lives_vec got %h want %h", dvec, mvec());
    end
  endtask

  task automatic test_timing();
    do_reset();
    go_play();
    strobe_pulse(3);
    n_tests++;
    if (time_alive !== 4'd3 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL level_pre got t=%0d lv=%0d want 3 0",
               time_alive, level);
    end
    strobe_pulse(1);
    n_tests++;
    if (level !== 3'd1) begin
      n_fail++;
      $display("FAIL level_wrap got %0d want 1", level);
    end
    strobe_pulse(13);
    n_tests++;
    if (time_alive !== 4'd15 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL time_sat got t=%0d lv=%0d want 15 4",
               time_alive, level);
    end
  endtask

  task automatic test_pause();
    do_reset();
    go_play();
    strobe_pulse(2);
    pause_btn = 1'b1; step();
    n_tests++;
    if (paused !== 1'b1 || playing !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_enter got pa=%b pl=%b want 1 0",
               paused, playing);
    end
    pulse = 1'b1; died = 1'b1; pw = 1'b1;
    jump = 1'b1;
    repeat (3) step();
    pulse = 1'b0; died = 1'b0; pw = 1'b0;
    jump = 1'b0; step();
    n_tests++;
    if (time_alive !== 4'd2 || num_lives !== 4'd2 ||
        paused !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_freeze got t=%0d lives=%0d pa=%b want 2 2 1",
               time_alive, num_lives, paused);
    end
    pause_btn = 1'b0; step();
    pause_btn = 1'b1; step();
    pause_btn = 1'b0;
    n_tests++;
    if (playing !== 1'b1 || paused !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_exit got pl=%b pa=%b want 1 0",
               playing, paused);
    end
    strobe_died();
    strobe_pulse(2);
    pause_btn = 1'b1; died = 1'b1; step();
    pause_btn = 1'b0; died = 1'b0;
    n_tests++;
    if (game_over !== 1'b1 || paused !== 1'b0) begin
      n_fail++;
      $display("FAIL fatal_vs_pause got go=%b pa=%b want 1 0",
               game_over, paused);
    end
    step();
  endtask

  task automatic test_best_and_reset();
    do_reset();
    go_play();
    strobe_died();
    strobe_pulse(5);
    strobe_died();
    go_play();
    strobe_died();
    strobe_pulse(3);
    strobe_died();
    n_tests++;
    if (best_time !== 4'd5 || time_alive !== 4'd3 ||
        game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL best_time got best=%0d t=%0d want 5 3",
               best_time, time_alive);
    end
    go_play();
    strobe_pulse(1);
    do_reset();
    n_tests++;
    if (reset_game !== 1'b1 || best_time !== 4'd0 ||
        time_alive !== 4'd0 || num_lives !== 4'd2 ||
        playing !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got %h want rg=1 best=0 lives=2", dvec);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      pulse = ($urandom_range(0, 1) == 0);
      died  = ($urandom_range(0, 5) == 0);
      pw    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) jump = ~jump;
      if ($urandom_range(0, 5) == 0) pause_btn = ~pause_btn;
      step();
      n_tests++;
      if (dvec !== mvec()) begin
        n_fail++;
        $display("FAIL random_%0d got %h want %h", i, dvec, mvec());
      end
    end
    rst = 1'b0; pulse = 1'b0; died = 1'b0;
    pw = 1'b0; jump = 1'b0; pause_btn = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_mode = MS; m_best = 0; m_prev = 0;
    clear_run();
    test_reset();
    test_start();
    test_hit_window();
    test_lives_cancel();
    test_timing();
    test_pause();
    test_best_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
